barrel_shift_pipe: RTL and testbench
====================================

Name: barrel_shift_pipe

Overview:
- Parametrised, pipelined barrel shifter/rotator. Generalises the fixed 16-bit rotate-by-8 stage to any WIDTH, any shift amount, four operations and a configurable pipeline depth.
- Valid/ready handshakes on input and output.
- Sits between the execute-stage operand muxes and the ALU result mux. Serves SLL, SRA, ROL and ROR instructions.

Parameters:
- WIDTH, 16, data width in bits; power of two, at least 4.
- STAGES, 2, number of register stages; must divide CNT_W = log2(WIDTH). Each stage resolves CNT_W/STAGES shift-amount bits, LSB group first.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  input operand valid
- in_ready  out  1  block can accept the input this cycle
- in_data  in  WIDTH  operand
- in_cnt  in  CNT_W  shift amount, 0..WIDTH-1
- in_op  in  2  operation: 00 ROL, 01 SLL, 10 ROR, 11 SRA
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_data  out  WIDTH  result
- out_zero  out  1  out_data == 0

Behaviour:
- Reset:
  - rst is asynchronous and active-high. Asserting it immediately clears every stage valid bit, so out_valid=0.
  - Data registers clear to 0, so out_data=0 and out_zero=1.
  - in_ready is 1 as soon as rst deasserts. Reset mid-operation discards all in-flight items, with no partial output.
- Transfers:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Pipeline:
  - Stage k (0..STAGES-1) holds valid_k, data_k, the remaining cnt bits and op_k.
  - Stage k loads from its predecessor when !valid_k, or when stage k+1 loads (k+1 = output consumer for the last stage).
  - in_ready = stage 0 load condition. This gives full throughput of 1 item/cycle with no bubbles when out_ready=1.
- Latency: exactly STAGES cycles from input transfer to out_valid, with no stall.
- Stall: with out_ready=0, the pipeline fills. After STAGES accepted items, in_ready=0. All held registers keep their values.
  - Items are never dropped, duplicated or reordered.
  - out_data is stable while out_valid && !out_ready.
- Stage k applies shift levels 2^j for j in [k*CNT_W/STAGES, (k+1)*CNT_W/STAGES), each gated by cnt bit j. Each level is a 2:1 mux per bit.
- Operations, with shift amount n:
  - ROL: bit i takes in[(i-n) mod WIDTH].
  - ROR: bit i takes in[(i+n) mod WIDTH].
  - SLL: vacated low bits are 0.
  - SRA: vacated high bits copy the original MSB, which is carried with the item through every stage.
- n=0: output equals input for all ops.
- n is always less than WIDTH; there is no overshift case.
- out_zero is combinational from the final data register.
- Simultaneous output transfer and input transfer on a full pipeline: both occur in the same cycle and the pipeline stays full.
- in_op and in_cnt are sampled only on input transfer. Values when in_valid=0 are don't-care.

Decomposition:
- Package barrel_shift_pkg holds:
  - op encodings OP_ROL=2'b00, OP_SLL=2'b01, OP_ROR=2'b10, OP_SRA=2'b11
  - a function computing CNT_W from WIDTH
- One sub-module, barrel_shift_level, parameters WIDTH and SHIFT.
  - Combinational; applies a single 2^SHIFT shift for the given op when enabled, built from the existing 2:1 bit mux.
  - barrel_shift_pipe instantiates CNT_W of these, with registers inserted every CNT_W/STAGES levels.

Test Plan:
- Reset: rst pulsed mid-stream with 2 items in flight -> out_valid=0 immediately, out_zero=1, in_ready=1 after release, and no stale result ever appears.
- ROL 0x12AB by 8, out_ready=1 -> out_data=0xAB12 exactly 2 cycles after the input transfer. ROR 0x0001 by 1 -> 0x8000.
- SRA 0x8001 by 3 -> 0xF000. SRA 0x7FF0 by 4 -> 0x07FF. SLL 0x0003 by 15 -> 0x8000. SLL 0x0000 by 5 -> 0x0000 with out_zero=1.
- Zero shift, all four ops on 0xA5C3 with cnt=0 -> 0xA5C3 each.
- Backpressure: out_ready=0, offer 3 items -> in_ready drops after 2 accepted. Raise out_ready -> all 3 results arrive in order, none lost or duplicated, out_data stable while stalled.
- Throughput: 16 back-to-back random items with out_ready=1 -> 16 consecutive out_valid cycles, all matching the reference model. Repeat with WIDTH=32, STAGES=5 and with STAGES=1.

Source files
------------

// File: rtl/barrel_shift_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation encodings
// and the shift-amount width derived from the data width.
package barrel_shift_pkg;

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_SRA = 2'b11;

  // Number of shift-amount bits needed to express 0..width-1.
  function automatic int calc_cnt_w(input int width);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < width) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/barrel_shift_level.sv
// One shift level: moves the operand by 2^SHIFT positions for the selected
// operation when enabled, otherwise passes it through (2:1 mux per bit).
module barrel_shift_level
  import barrel_shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHIFT = 0
) (
  input  logic             en_i,
  input  logic [1:0]       op_i,
  input  logic             msb_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  localparam int DIST = 1 << SHIFT;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic left_bit;
    logic right_bit;
    logic shifted_bit;

    // Bits that fall off one end wrap for rotates, else take the fill value.
    if (gi >= DIST) begin : g_left_in
      assign left_bit = data_i[gi-DIST];
    end else begin : g_left_fill
      assign left_bit = (op_i == OP_ROL) ? data_i[gi-DIST+WIDTH] : 1'b0;
    end

    if (gi + DIST < WIDTH) begin : g_right_in
      assign right_bit = data_i[gi+DIST];
    end else begin : g_right_fill
      assign right_bit = (op_i == OP_ROR) ? data_i[gi+DIST-WIDTH] : msb_i;
    end

    assign shifted_bit = op_i[1] ? right_bit : left_bit;
    assign data_o[gi]  = en_i ? shifted_bit : data_i[gi];
  end

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter/rotator (ROL, SLL, ROR, SRA) with valid/ready on
// both sides; each register stage resolves CNT_W/STAGES shift-amount bits.
module barrel_shift_pipe
  import barrel_shift_pkg::*;
#(
  parameter  int WIDTH  = 16,
  parameter  int STAGES = 2,
  localparam int CNT_W  = calc_cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_cnt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  localparam int GRP = CNT_W / STAGES;

  logic [STAGES:0]                load;
  logic [STAGES-1:0]              valid_src;
  logic [STAGES-1:0][WIDTH-1:0]   data_src;
  logic [CNT_W-1:0]               cnt_src [STAGES];
  logic [STAGES-1:0][1:0]         op_src;
  logic [STAGES-1:0]              msb_src;
  logic [STAGES-1:0]              stage_valid;
  logic [STAGES-1:0][WIDTH-1:0]   stage_data;

  // A stage may load when it is empty or when its successor takes its item.
  always_comb begin
    load         = '0;
    load[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      load[k] = !stage_valid[k] || load[k+1];
    end
  end

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic [GRP:0][WIDTH-1:0] lvl;
    logic                    valid_q;
    logic [WIDTH-1:0]        data_q;
    logic [WIDTH-1:0]        data_d;

    // Sideband feeding stage gi is captured alongside the item entering gi-1.
    if (gi == 0) begin : g_head
      assign valid_src[gi] = in_valid;
      assign data_src[gi]  = in_data;
      assign cnt_src[gi]   = in_cnt;
      assign op_src[gi]    = in_op;
      assign msb_src[gi]   = in_data[WIDTH-1];
    end else begin : g_link
      logic [CNT_W-1:0] cnt_q;
      logic [1:0]       op_q;
      logic             msb_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q <= '0;
          op_q  <= OP_ROL;
          msb_q <= 1'b0;
        end else if (load[gi-1] && valid_src[gi-1]) begin
          cnt_q <= cnt_src[gi-1];
          op_q  <= op_src[gi-1];
          msb_q <= msb_src[gi-1];
        end
      end

      assign valid_src[gi] = stage_valid[gi-1];
      assign data_src[gi]  = stage_data[gi-1];
      assign cnt_src[gi]   = cnt_q;
      assign op_src[gi]    = op_q;
      assign msb_src[gi]   = msb_q;
    end

    assign lvl[0] = data_src[gi];

    for (genvar gj = 0; gj < GRP; gj++) begin : g_lvl
      barrel_shift_level #(
        .WIDTH (WIDTH),
        .SHIFT (gi * GRP + gj)
      ) u_level (
        .en_i   (cnt_src[gi][gi*GRP+gj]),
        .op_i   (op_src[gi]),
        .msb_i  (msb_src[gi]),
        .data_i (lvl[gj]),
        .data_o (lvl[gj+1])
      );
    end

    assign data_d = lvl[GRP];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else if (load[gi]) begin
        valid_q <= valid_src[gi];
        if (valid_src[gi]) data_q <= data_d;
      end
    end

    assign stage_valid[gi] = valid_q;
    assign stage_data[gi]  = data_q;
  end

  assign in_ready  = load[0];
  assign out_valid = stage_valid[STAGES-1];
  assign out_data  = stage_data[STAGES-1];
  assign out_zero  = (stage_data[STAGES-1] == '0);

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Self-checking bench: three shifter configurations (16/2, 32/5, 16/1) driven
// with directed and random items, checked against an arithmetic shift model.
module tb_barrel_shift_pipe;

  logic clk;
  logic rst;

  logic        iv   [3];
  logic        ir   [3];
  logic        ov   [3];
  logic        ordy [3];
  logic        oz   [3];
  logic [31:0] idat [3];
  logic [4:0]  icnt [3];
  logic [1:0]  iop  [3];
  logic [31:0] od   [3];
  logic [15:0] a_od;
  logic [31:0] b_od;
  logic [15:0] c_od;

  int W [3] = '{16, 32, 16};
  int S [3] = '{2, 5, 1};

  int checks   = 0;
  int failures = 0;

  logic [31:0] it_d [3][32];
  logic [4:0]  it_c [3][32];
  logic [1:0]  it_o [3][32];

  barrel_shift_pipe #(.WIDTH(16), .STAGES(2)) u_a (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(idat[0][15:0]), .in_cnt(icnt[0][3:0]), .in_op(iop[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(a_od), .out_zero(oz[0]));

  barrel_shift_pipe #(.WIDTH(32), .STAGES(5)) u_b (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(idat[1]), .in_cnt(icnt[1]), .in_op(iop[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(b_od), .out_zero(oz[1]));

  barrel_shift_pipe #(.WIDTH(16), .STAGES(1)) u_c (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_data(idat[2][15:0]), .in_cnt(icnt[2][3:0]), .in_op(iop[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(c_od), .out_zero(oz[2]));

  always_comb begin
    od[0] = {16'h0, a_od};
    od[1] = b_od;
    od[2] = {16'h0, c_od};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: shifts and rotates written directly as integer arithmetic.
  function automatic logic [31:0] model(input int w, input logic [31:0] d,
                                        input int n, input logic [1:0] op);
    longint unsigned mask, x, r;
    mask = (64'd1 << w) - 64'd1;
    x    = {32'h0, d} & mask;
    case (op)
      2'b00:   r = (x << n) | (x >> (w - n));
      2'b01:   r = x << n;
      2'b10:   r = (x >> n) | (x << (w - n));
      default: begin
        r = x >> n;
        if (x[w-1]) r = r | (mask & ~(mask >> n));
      end
    endcase
    return 32'(r & mask);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 3; i++) begin
      iv[i]   = 1'b0;
      idat[i] = '0;
      icnt[i] = '0;
      iop[i]  = 2'b00;
      ordy[i] = 1'b1;
    end
  endtask

  // Single item into the 16/2 instance; result must appear exactly 2 cycles later.
  task automatic directed(input string tag, input logic [1:0] op, input logic [15:0] d,
                          input logic [4:0] n, input logic [15:0] exp);
    @(posedge clk); #1;
    iv[0] = 1'b1; idat[0] = {16'h0, d}; icnt[0] = n; iop[0] = op; ordy[0] = 1'b1;
    @(negedge clk);
    check({tag, ".ready"}, {31'h0, ir[0]}, 32'h1);
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(negedge clk);
    check({tag, ".early"}, {31'h0, ov[0]}, 32'h0);
    @(negedge clk);
    check({tag, ".valid"}, {31'h0, ov[0]}, 32'h1);
    check({tag, ".data"}, od[0], {16'h0, exp});
    check({tag, ".zero"}, {31'h0, oz[0]}, {31'h0, exp == 16'h0});
  endtask

  task automatic gen_items(input int n);
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < n; k++) begin
        it_d[i][k] = $urandom() & ((W[i] == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF);
        it_c[i][k] = 5'($urandom_range(0, W[i] - 1));
        it_o[i][k] = 2'($urandom_range(0, 3));
      end
    end
  endtask

  // Stream n items into all instances, holding out_ready low for 'stall' cycles.
  task automatic run_stream(input string tag, input int n, input int stall);
    int sent [3];
    int got [3];
    int first_out [3];
    int last_out [3];
    logic [31:0] hold [3];
    bit hold_v [3];
    int cyc;
    int extra;
    logic [31:0] exp;
    for (int i = 0; i < 3; i++) begin
      sent[i] = 0; got[i] = 0; first_out[i] = -1; last_out[i] = -1; hold_v[i] = 1'b0;
    end
    cyc = 0;
    while ((got[0] < n || got[1] < n || got[2] < n) && cyc < 200) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        iv[i]   = (sent[i] < n);
        idat[i] = (sent[i] < n) ? it_d[i][sent[i]] : '0;
        icnt[i] = (sent[i] < n) ? it_c[i][sent[i]] : '0;
        iop[i]  = (sent[i] < n) ? it_o[i][sent[i]] : 2'b00;
        ordy[i] = (cyc >= stall);
      end
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (ov[i] && !ordy[i]) begin
          if (hold_v[i]) check($sformatf("%s.u%0d.hold", tag, i), od[i], hold[i]);
          hold[i]   = od[i];
          hold_v[i] = 1'b1;
        end
        if (ov[i] && ordy[i]) begin
          if (got[i] < n) begin
            exp = model(W[i], it_d[i][got[i]], int'(it_c[i][got[i]]), it_o[i][got[i]]);
            check($sformatf("%s.u%0d.data%0d", tag, i, got[i]), od[i], exp);
            check($sformatf("%s.u%0d.zero%0d", tag, i, got[i]), {31'h0, oz[i]},
                  {31'h0, exp == 32'h0});
          end
          if (first_out[i] < 0) first_out[i] = cyc;
          last_out[i] = cyc;
          got[i]++;
        end
        if (iv[i] && ir[i]) sent[i]++;
        if (stall > 0 && cyc == stall - 1) begin
          check($sformatf("%s.u%0d.accepted", tag, i), sent[i], (n < S[i]) ? n : S[i]);
          if (n > S[i]) check($sformatf("%s.u%0d.in_ready", tag, i), {31'h0, ir[i]}, 32'h0);
        end
      end
      cyc++;
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s.u%0d.count", tag, i), got[i], n);
      if (stall == 0) begin
        check($sformatf("%s.u%0d.latency", tag, i), first_out[i], S[i]);
        check($sformatf("%s.u%0d.burst", tag, i), last_out[i] - first_out[i] + 1, n);
      end
    end
    idle_inputs();
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (ov[i]) extra++;
    end
    check({tag, ".no_extra"}, extra, 0);
  endtask

  initial begin
    int stale;
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    check("reset.valid", {31'h0, ov[0]}, 32'h0);
    check("reset.data", od[0], 32'h0);
    check("reset.zero", {31'h0, oz[0]}, 32'h1);
    rst = 1'b0;
    #1;
    check("reset.ready", {31'h0, ir[0]}, 32'h1);

    directed("rol8",  2'b00, 16'h12AB, 5'd8,  16'hAB12);
    directed("ror1",  2'b10, 16'h0001, 5'd1,  16'h8000);
    directed("sra3",  2'b11, 16'h8001, 5'd3,  16'hF000);
    directed("sra4",  2'b11, 16'h7FF0, 5'd4,  16'h07FF);
    directed("sll15", 2'b01, 16'h0003, 5'd15, 16'h8000);
    directed("sll5z", 2'b01, 16'h0000, 5'd5,  16'h0000);
    directed("n0rol", 2'b00, 16'hA5C3, 5'd0,  16'hA5C3);
    directed("n0sll", 2'b01, 16'hA5C3, 5'd0,  16'hA5C3);
    directed("n0ror", 2'b10, 16'hA5C3, 5'd0,  16'hA5C3);
    directed("n0sra", 2'b11, 16'hA5C3, 5'd0,  16'hA5C3);

    // Two items in flight, then an asynchronous reset between clock edges.
    @(posedge clk); #1;
    iv[0] = 1'b1; idat[0] = 32'h0000_1234; icnt[0] = 5'd4; iop[0] = 2'b00;
    @(posedge clk); #1;
    idat[0] = 32'h0000_F00F; icnt[0] = 5'd2;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    check("midrst.inflight", {31'h0, ov[0]}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("midrst.valid", {31'h0, ov[0]}, 32'h0);
    check("midrst.zero", {31'h0, oz[0]}, 32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst.ready", {31'h0, ir[0]}, 32'h1);
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ov[0]) stale++;
    end
    check("midrst.stale", stale, 0);

    gen_items(3);
    run_stream("bp", 3, 6);
    gen_items(16);
    run_stream("tput", 16, 0);
    gen_items(16);
    run_stream("tput2", 16, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
